rr_mux_arbiter: RTL and testbench
=================================

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter: HOLD_MAX, default 4, maximum cycles one grant is held when timeout is compiled in; legal range 1..255.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: Req  input  8  per-requester request for the shared 8:1 mux; Req[i] selects mux input A[i].
REQ-005 Port: Done  input  1  current owner releases the mux; meaningful only while Valid=1.
REQ-006 Port: Sel  output  3  registered select driven to the 8:1 mux; binary index of current owner.
REQ-007 Port: Grant  output  8  registered one-hot owner vector; all-zero when no owner.
REQ-008 Port: Valid  output  1  registered; 1 while a grant is active.

Function
REQ-009 Two states SHALL exist: IDLE (no owner) and GRANT (one owner).
REQ-010 Internal pointer ptr (3 bits) SHALL hold the index of the last released owner.
REQ-011 Winner SHALL be the first i with Req[i]=1, searching indices ptr+1, ptr+2, ... modulo 8 (ptr itself is searched last).
REQ-012 IDLE with any Req bit set at edge N SHALL enter GRANT at edge N with Sel=winner, Grant=1<<winner, Valid=1; outputs are visible one cycle after Req is sampled.
REQ-013 IDLE with Req=0 SHALL remain IDLE; Sel SHALL keep its last value, Grant=0, Valid=0.
REQ-014 In GRANT, a release condition is Done=1, or Req[Sel]=0, or timeout (REQ-024).
REQ-015 On release at edge N, ptr SHALL load Sel; if any Req bit is set, the next winner (computed with the updated ptr per REQ-011) SHALL be granted at the same edge N, with no idle cycle.
REQ-016 On release with Req=0, next state SHALL be IDLE with Grant=0, Valid=0, Sel unchanged.
REQ-017 On release with only Req[Sel] still set, the same index SHALL be regranted (Valid stays 1, hold counter restarts).
REQ-018 Without a release condition, Sel, Grant and Valid SHALL remain stable.
REQ-019 Grant SHALL always equal one-hot decode of Sel when Valid=1, and SHALL be zero when Valid=0.
REQ-020 Done in IDLE SHALL be ignored.

Reset
REQ-021 rst=1 SHALL immediately force state=IDLE, Sel=3'd0, Grant=8'd0, Valid=0, ptr=3'd7, hold counter=0, independent of clk.
REQ-022 Reset asserted mid-grant SHALL drop ownership without a release cycle; after rst deasserts, the first grant SHALL follow REQ-011 from ptr=7, so index 0 has top priority.

Configuration
REQ-023 Macro RR_MUX_ARB_TIMEOUT_EN SHALL compile the hold counter and timeout in or out.
REQ-024 With the macro defined: an 8-bit hold counter SHALL clear on each new grant and increment each GRANT cycle; when it reaches HOLD_MAX-1 with no other release, that edge SHALL be a release, so a grant lasts at most HOLD_MAX cycles.
REQ-025 Without the macro: no counter SHALL exist; a grant SHALL persist until Done=1 or Req[Sel]=0.

Structure
REQ-026 Package mux_arb_pkg SHALL hold N_REQ=8, SEL_W=3, and the state enum {IDLE, GRANT}.
REQ-027 Sub-module rr_priority_pick SHALL implement the combinational rotating-priority search (inputs Req and ptr; outputs winner index and any flag), instantiated once.

Verification
REQ-028 After reset, Req=8'b0000_0001 -> one cycle later Sel=0, Grant=8'h01, Valid=1; Done pulse with Req=0 -> next cycle Valid=0, Grant=0, Sel=0.
REQ-029 Req=8'hFF held, Done pulsed every cycle -> Sel sequence 0,1,2,...,7,0 with Valid constantly 1 and no idle cycle.
REQ-030 Owner 3, Req=8'b1000_1001, Req[3] dropped -> next Sel=7, then after release Sel=0; index 3 is not regranted.
REQ-031 Macro defined, HOLD_MAX=4, Req=8'h06, Done=0 -> Sel=1 for exactly 4 cycles, then Sel=2 for 4 cycles, then Sel=1; macro undefined -> Sel=1 indefinitely.
REQ-032 rst asserted mid-grant with Sel=5 between clock edges -> Valid=0, Grant=0, Sel=0 before the next edge; with Req=8'h21 after deassert -> Sel=0 granted first.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux_arb_pkg
// Shared constants and types for the round-robin 8:1 mux arbiter.
//   N_REQ   : number of requesters / mux inputs
//   SEL_W   : width of the binary mux select
//   state_t : arbiter state (IDLE = no owner, GRANT = one owner)
// ---------------------------------------------------------------------------
package mux_arb_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage : mux_arb_pkg

// File: rtl/rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
// Combinational rotating-priority search. Scans ptr+1, ptr+2, ... modulo
// N_REQ, so ptr itself has the lowest priority, and returns the first
// requesting index.
// Ports:
//   req    in  [N_REQ-1:0]  request vector
//   ptr    in  [SEL_W-1:0]  index of the last released owner
//   winner out [SEL_W-1:0]  first requesting index after ptr (ptr if none)
//   any    out              1 when at least one request bit is set
// ---------------------------------------------------------------------------
module rr_priority_pick
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] winner,
    output logic             any
);

    logic [SEL_W-1:0] idx;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        winner = ptr;
        any    = 1'b0;
        idx    = ptr;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = SEL_W'(ptr + k);
            if (!any && req[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

endmodule : rr_priority_pick

// File: rtl/rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter
// Round-robin arbiter owning the select of a shared 8:1 mux. One requester
// owns the mux at a time; on release the next requester after the released
// one is granted on the same edge, with no idle cycle.
// Optional macro RR_MUX_ARB_TIMEOUT_EN compiles in a hold counter that forces
// a release after HOLD_MAX cycles of one grant.
// Parameters:
//   HOLD_MAX  maximum grant length in cycles with the timeout built (1..255)
// Ports:
//   clk    in       rising-edge clock
//   rst    in       asynchronous active-high reset
//   Req    in  [7:0] per-requester request; Req[i] selects mux input A[i]
//   Done   in       current owner releases the mux (ignored while idle)
//   Sel    out [2:0] registered binary select of the current owner
//   Grant  out [7:0] registered one-hot owner vector, zero when idle
//   Valid  out      registered, 1 while a grant is active
// ---------------------------------------------------------------------------
module rr_mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int HOLD_MAX = 4
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] Req,
    input  logic             Done,
    output logic [SEL_W-1:0] Sel,
    output logic [N_REQ-1:0] Grant,
    output logic             Valid
);

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("rr_mux_arbiter: HOLD_MAX must be in 1..255");
    end

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ptr_q,   ptr_d;
    logic [SEL_W-1:0] sel_q,   sel_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             valid_q, valid_d;

    logic             release_c;  // owner gives up the mux at this edge
    logic             load_new;   // a (re)grant is loaded at this edge
    logic [SEL_W-1:0] pick_ptr;
    logic [SEL_W-1:0] win;
    logic             win_any;

`ifdef RR_MUX_ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
    logic       timeout;

    assign timeout   = (hold_q == 8'(HOLD_MAX - 1));
    assign release_c = Done | ~Req[sel_q] | timeout;
`else
    assign release_c = Done | ~Req[sel_q];
`endif

    // On a release the search must start after the owner being released,
    // which is the ptr value that only becomes visible next cycle.
    assign pick_ptr = (state_q == GRANT && release_c) ? sel_q : ptr_q;

    rr_priority_pick u_pick (
        .req    (Req),
        .ptr    (pick_ptr),
        .winner (win),
        .any    (win_any)
    );

    // State register: state, pointer, registered outputs and hold counter.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 3'd7;
            sel_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
`ifdef RR_MUX_ARB_TIMEOUT_EN
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
`ifdef RR_MUX_ARB_TIMEOUT_EN
            hold_q  <= hold_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        load_new = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_any) begin
                    state_d  = GRANT;
                    load_new = 1'b1;
                end
            end
            GRANT: begin
                if (release_c) begin
                    ptr_d = sel_q;
                    if (win_any) load_new = 1'b1;
                    else         state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef RR_MUX_ARB_TIMEOUT_EN
        hold_d = hold_q;
        if (load_new || state_d == IDLE) hold_d = '0;
        else if (state_q == GRANT)       hold_d = hold_q + 8'd1;
`endif
    end

    // Output logic: next values of the registered outputs. Sel is left alone
    // when dropping to IDLE so the mux keeps its last selection.
    always_comb begin
        sel_d   = sel_q;
        grant_d = grant_q;
        valid_d = valid_q;
        if (load_new) begin
            sel_d   = win;
            grant_d = N_REQ'(1) << win;
            valid_d = 1'b1;
        end else if (state_d == IDLE) begin
            grant_d = '0;
            valid_d = 1'b0;
        end
    end

    assign Sel   = sel_q;
    assign Grant = grant_q;
    assign Valid = valid_q;

endmodule : rr_mux_arbiter

// File: tb/tb_rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_mux_arbiter
// Self-checking bench for rr_mux_arbiter. A behavioural model tracks the
// owner as an integer (-1 = none) plus the last released index, and derives
// Sel/Grant/Valid from that after every clock edge.
// ---------------------------------------------------------------------------
module tb_rr_mux_arbiter;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] Req;
    logic       Done;
    logic [2:0] Sel;
    logic [7:0] Grant;
    logic       Valid;

    rr_mux_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk   (clk),
        .rst   (rst),
        .Req   (Req),
        .Done  (Done),
        .Sel   (Sel),
        .Grant (Grant),
        .Valid (Valid)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state.
    int         m_owner;  // current owner index, -1 when idle
    int         m_last;   // last released owner
    int         m_age;    // cycles held beyond the first
    logic [2:0] m_sel;    // select value the mux sees

    function automatic int find_next(input logic [7:0] r, input int last);
        for (int k = 1; k <= 8; k++) begin
            if (r[(last + k) % 8]) return (last + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 7;
        m_age   = 0;
        m_sel   = 3'd0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic d);
        int  w;
        bit  rel;
        if (m_owner < 0) begin
            w = find_next(r, m_last);
            if (w >= 0) begin
                m_owner = w;
                m_sel   = 3'(w);
                m_age   = 0;
            end
        end else begin
            rel = d || !r[m_owner];
`ifdef RR_MUX_ARB_TIMEOUT_EN
            rel = rel || (m_age == HOLD - 1);
`endif
            if (rel) begin
                m_last = m_owner;
                w = find_next(r, m_last);
                if (w >= 0) begin
                    m_owner = w;
                    m_sel   = 3'(w);
                    m_age   = 0;
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic check(input string tag);
        logic [7:0] exp_grant;
        logic       exp_valid;
        exp_valid = (m_owner >= 0);
        exp_grant = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
        n_total++;
        assert (Sel === m_sel) n_pass++;
        else $error("FAIL %s sel observed=%0d expected=%0d", tag, Sel, m_sel);
        n_total++;
        assert (Grant === exp_grant) n_pass++;
        else $error("FAIL %s grant observed=%h expected=%h", tag, Grant, exp_grant);
        n_total++;
        assert (Valid === exp_valid) n_pass++;
        else $error("FAIL %s valid observed=%b expected=%b", tag, Valid, exp_valid);
    endtask

    // One clock: drive at the falling edge, model the rising edge, check at
    // the following falling edge.
    task automatic cyc(input logic [7:0] r, input logic d, input string tag);
        Req  = r;
        Done = d;
        @(posedge clk);
        model_step(r, d);
        @(negedge clk);
        check(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check("reset_held");
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] r;
        logic       d;

        Req  = 8'h00;
        Done = 1'b0;
        rst  = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_state");
        rst = 1'b0;

        // Single requester, then release with nobody waiting.
        cyc(8'h01, 1'b0, "single_grant");
        cyc(8'h00, 1'b1, "release_to_idle");
        cyc(8'h00, 1'b1, "done_in_idle");

        // All requesting, Done every cycle: 0,1,...,7,0 with no gap.
        do_reset();
        cyc(8'hFF, 1'b0, "all_first");
        for (int i = 0; i < 8; i++) cyc(8'hFF, 1'b1, "all_rotate");

        // Owner 3 drops its request: 7 next, then wrap to 0, never 3.
        do_reset();
        cyc(8'h08, 1'b0, "own3");
        cyc(8'h89, 1'b0, "own3_hold");
        cyc(8'h81, 1'b0, "drop3_to7");
        cyc(8'h81, 1'b1, "rel7_to0");
        cyc(8'h00, 1'b1, "idle_again");

        // Only the owner still requesting after Done: regranted.
        cyc(8'h04, 1'b0, "own2");
        cyc(8'h04, 1'b1, "regrant2");
        cyc(8'h04, 1'b0, "regrant2_hold");

        // Two requesters, no Done: timeout alternates them when built in,
        // otherwise index 1 holds forever.
        do_reset();
        for (int i = 0; i < 13; i++) cyc(8'h06, 1'b0, "hold_06");

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            d = ($urandom_range(0, 3) == 0);
            cyc(r, d, "random");
        end

        // Asynchronous reset in the middle of a grant to index 5.
        do_reset();
        cyc(8'h20, 1'b0, "own5");
        #2 rst = 1'b1;
        model_reset();
        #1 check("async_reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc(8'h21, 1'b0, "post_reset_0");
        cyc(8'h21, 1'b1, "post_reset_5");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_rr_mux_arbiter
